video_stream_aligner: RTL and testbench

// - Pixel-domain successor of the DRAM video read path: unpacks CHUNK_W-bit AXI-stream chunks into PIXEL_W pixels.
// - Paces pixels against HDMI h/v counters and keeps stream frames locked to display frames; tlast marks a frame's last chunk.
// - Recovers automatically from short/long frames and underflow; sits between clockdomain_fifo receiver side and the TMDS encoder.

---
 rtl/video_stream_aligner_if.sv | 29 ++
 rtl/video_stream_aligner.sv | 192 +++++++++++++++++++
 tb/tb_video_stream_aligner.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_stream_aligner_if.sv
`default_nettype none
// ============================================================================
//  Module      : video_stream_aligner_if
//  Description : AXI-stream chunk channel feeding the video stream aligner.
//  Revision    : 1.0 - initial release
// ============================================================================
interface video_stream_aligner_if #(
    parameter int CHUNK_W = 128
);
    logic               chunk_tvalid;
    logic               chunk_tready;
    logic [CHUNK_W-1:0] chunk_tdata;
    logic               chunk_tlast;

    modport master (
        output chunk_tvalid,
        output chunk_tdata,
        output chunk_tlast,
        input  chunk_tready
    );

    modport slave (
        input  chunk_tvalid,
        input  chunk_tdata,
        input  chunk_tlast,
        output chunk_tready
    );
endinterface
`default_nettype wire

// File: rtl/video_stream_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : video_stream_aligner
//  Description : Unpacks AXI-stream chunks into pixels paced by HDMI counters,
//                keeping stream frames locked to display frames.
//                Optional statistics outputs: VIDEO_ALIGNER_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_stream_aligner #(
    parameter int                 CHUNK_W    = 128,
    parameter int                 PIXEL_W    = 16,
    parameter int                 H_ACTIVE   = 1280,
    parameter int                 V_ACTIVE   = 720,
    parameter int                 H_W        = 11,
    parameter int                 V_W        = 10,
    parameter logic [PIXEL_W-1:0] FILL_COLOR = 16'hF800
) (
    input  wire logic                clk_pixel,
    input  wire logic                rst_pixel,
    input  wire logic [H_W-1:0]      h_count,
    input  wire logic [V_W-1:0]      v_count,
    input  wire logic                active_draw,
    video_stream_aligner_if.slave    chunk,
    output logic      [PIXEL_W-1:0]  pixel,
    output logic                     pixel_valid,
    output logic                     frame_locked
`ifdef VIDEO_ALIGNER_STATS_EN
    ,
    output logic      [15:0]         underflow_count,
    output logic      [15:0]         resync_count
`endif
);

    localparam int c_N     = CHUNK_W / PIXEL_W;
    localparam int c_IDX_W = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_N - 1);
    localparam logic [H_W-1:0]     c_H_LAST   = H_W'(H_ACTIVE - 1);
    localparam logic [V_W-1:0]     c_V_LAST   = V_W'(V_ACTIVE - 1);

    generate
        if ((CHUNK_W % PIXEL_W) != 0 || c_N < 1) begin : g_bad_width
            $error("video_stream_aligner: CHUNK_W must be an integer multiple of PIXEL_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_SEEK = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [CHUNK_W-1:0]   r_buf;
    logic                 r_buf_last;
    logic                 r_full;
    logic [c_IDX_W-1:0]   r_idx;
    logic [PIXEL_W-1:0]   r_pixel;
    logic                 r_pixel_valid;

    logic [PIXEL_W-1:0]   w_head;
    logic                 w_head_last;
    logic                 w_eof;
    logic                 w_pop;
    logic                 w_show;
    logic                 w_ready;
    logic                 w_load;

    assign w_head      = r_buf[r_idx*PIXEL_W +: PIXEL_W];
    assign w_head_last = r_full && r_buf_last && (r_idx == c_LAST_IDX);
    assign w_eof       = (h_count == c_H_LAST) && (v_count == c_V_LAST) && active_draw;

    // A new chunk may land in the same cycle the final pixel of the old one leaves.
    assign w_ready            = !rst_pixel && (!r_full || (w_pop && (r_idx == c_LAST_IDX)));
    assign w_load             = chunk.chunk_tvalid && w_ready;
    assign chunk.chunk_tready = w_ready;

    always_ff @(posedge clk_pixel) begin
        if (rst_pixel) begin
            r_state <= ST_SEEK;
        end else begin
            r_state <= w_state_next;
        end
    end

    // w_pop is only ever raised with a head present, so it doubles as consume.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_show       = 1'b0;
        case (r_state)
            ST_SEEK: begin
                w_pop = r_full;
                if (w_head_last) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_eof) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_eof) begin
                    if (r_full) begin
                        w_pop  = 1'b1;
                        w_show = 1'b1;
                        if (!w_head_last) begin
                            w_state_next = ST_SEEK;
                        end
                    end else begin
                        w_state_next = ST_SEEK;
                    end
                end else if (active_draw && r_full && !w_head_last) begin
                    w_pop  = 1'b1;
                    w_show = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_SEEK;
            end
        endcase
    end

    always_ff @(posedge clk_pixel) begin
        if (rst_pixel) begin
            r_buf      <= '0;
            r_buf_last <= 1'b0;
            r_full     <= 1'b0;
            r_idx      <= '0;
        end else if (w_load) begin
            r_buf      <= chunk.chunk_tdata;
            r_buf_last <= chunk.chunk_tlast;
            r_full     <= 1'b1;
            r_idx      <= '0;
        end else if (w_pop) begin
            if (r_idx == c_LAST_IDX) begin
                r_full <= 1'b0;
                r_idx  <= '0;
            end else begin
                r_idx  <= r_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (rst_pixel) begin
            r_pixel       <= FILL_COLOR;
            r_pixel_valid <= 1'b0;
        end else begin
            r_pixel       <= w_show ? w_head : FILL_COLOR;
            r_pixel_valid <= w_show;
        end
    end

    assign pixel        = r_pixel;
    assign pixel_valid  = r_pixel_valid;
    assign frame_locked = (r_state == ST_RUN);

`ifdef VIDEO_ALIGNER_STATS_EN
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic [15:0] r_underflow_cnt;
    logic [15:0] r_resync_cnt;
    logic        w_underflow;
    logic        w_resync;

    // An eof that does not consume the frame's tlast pixel means lost alignment.
    assign w_underflow = (r_state == ST_RUN) && active_draw && !r_full;
    assign w_resync    = (r_state == ST_RUN) && w_eof && !w_head_last;

    always_ff @(posedge clk_pixel) begin
        if (rst_pixel) begin
            r_underflow_cnt <= '0;
            r_resync_cnt    <= '0;
        end else begin
            if (w_underflow && (r_underflow_cnt != c_CNT_MAX)) begin
                r_underflow_cnt <= r_underflow_cnt + 16'd1;
            end
            if (w_resync && (r_resync_cnt != c_CNT_MAX)) begin
                r_resync_cnt <= r_resync_cnt + 16'd1;
            end
        end
    end

    assign underflow_count = r_underflow_cnt;
    assign resync_count    = r_resync_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_video_stream_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_stream_aligner
//  Description : Directed frame-sequence bench for video_stream_aligner.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_stream_aligner;

    localparam int          c_CW   = 64;
    localparam int          c_HA   = 8;
    localparam int          c_VA   = 4;
    localparam int          c_HT   = 12;
    localparam int          c_VT   = 6;
    localparam int          c_NF   = 13;
    localparam logic [15:0] c_FILL = 16'hF800;

    logic        clk = 1'b0;
    logic        rst_pixel;
    logic [3:0]  h_count;
    logic [2:0]  v_count;
    logic        active_draw;
    logic [15:0] pixel;
    logic        pixel_valid;
    logic        frame_locked;
`ifdef VIDEO_ALIGNER_STATS_EN
    logic [15:0] underflow_count;
    logic [15:0] resync_count;
`endif

    always #5 clk = ~clk;

    video_stream_aligner_if #(.CHUNK_W(c_CW)) vif ();

    video_stream_aligner #(
        .CHUNK_W    (c_CW),
        .PIXEL_W    (16),
        .H_ACTIVE   (c_HA),
        .V_ACTIVE   (c_VA),
        .H_W        (4),
        .V_W        (3),
        .FILL_COLOR (c_FILL)
    ) dut (
        .clk_pixel       (clk),
        .rst_pixel       (rst_pixel),
        .h_count         (h_count),
        .v_count         (v_count),
        .active_draw     (active_draw),
        .chunk           (vif),
        .pixel           (pixel),
        .pixel_valid     (pixel_valid),
        .frame_locked    (frame_locked)
`ifdef VIDEO_ALIGNER_STATS_EN
        ,
        .underflow_count (underflow_count),
        .resync_count    (resync_count)
`endif
    );

    typedef struct {
        logic [63:0] data;
        logic        last;
    } chunk_t;

    // Expected picture of one display frame: positions below n_run show base+k,
    // optionally position 31 shows base+tail_idx, the rest is fill.
    typedef struct {
        int base;
        int n_run;
        bit tail_valid;
        int tail_idx;
        bit locked;
        int uf;
        int rs;
    } frame_exp_t;

    chunk_t      src_q[$];
    frame_exp_t  tbl [c_NF];
    logic [16:0] obs [c_NF][32];
    int          blank_err [c_NF];
    logic        locked_end [c_NF];
    logic [15:0] uf_end [c_NF];
    logic [15:0] rs_end [c_NF];

    int h = 0;
    int v = 0;
    int d = 0;
    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input int f, input int nch);
        for (int c = 0; c < nch; c++) begin
            chunk_t ch;
            for (int i = 0; i < 4; i++) begin
                ch.data[16*i +: 16] = 16'(f*64 + 4*c + i);
            end
            ch.last = (c == nch - 1);
            src_q.push_back(ch);
        end
    endtask

    task automatic set_exp(input int idx, input int base, input int n_run, input bit tv,
                           input int ti, input bit lk, input int uf, input int rs);
        tbl[idx].base       = base;
        tbl[idx].n_run      = n_run;
        tbl[idx].tail_valid = tv;
        tbl[idx].tail_idx   = ti;
        tbl[idx].locked     = lk;
        tbl[idx].uf         = uf;
        tbl[idx].rs         = rs;
    endtask

    // One pixel clock: drive counts/stream, handshake at the edge, sample #1 later.
    task automatic cycle();
        logic fire;
        int   ph;
        int   pv;
        int   pd;
        logic pad;
        logic src_on;
        h_count     = 4'(h);
        v_count     = 3'(v);
        active_draw = (h < c_HA) && (v < c_VA);
        rst_pixel   = (d == 11) && (v == 0) && (h == 2);
        src_on      = !((d == 8) && ((v > 2) || ((v == 2) && (h >= 4))));
        vif.chunk_tvalid = src_on && (src_q.size() > 0);
        if (vif.chunk_tvalid) begin
            vif.chunk_tdata = src_q[0].data;
            vif.chunk_tlast = src_q[0].last;
        end else begin
            vif.chunk_tdata = '0;
            vif.chunk_tlast = 1'b0;
        end
        #1;
        if (rst_pixel) begin
            check("tready_in_reset", 32'(vif.chunk_tready), 32'd0);
        end
        fire = vif.chunk_tvalid && vif.chunk_tready;
        ph = h; pv = v; pd = d; pad = active_draw;
        @(posedge clk);
        #1;
        if (fire) begin
            void'(src_q.pop_front());
        end
        if (pad) begin
            obs[pd][pv*c_HA + ph] = {pixel_valid, pixel};
        end else if ({pixel_valid, pixel} !== {1'b0, c_FILL}) begin
            blank_err[pd]++;
        end
        if ((ph == c_HT - 1) && (pv == c_VT - 1)) begin
            locked_end[pd] = frame_locked;
`ifdef VIDEO_ALIGNER_STATS_EN
            uf_end[pd] = underflow_count;
            rs_end[pd] = resync_count;
`else
            uf_end[pd] = '0;
            rs_end[pd] = '0;
`endif
        end
        h++;
        if (h == c_HT) begin
            h = 0;
            v++;
            if (v == c_VT) begin
                v = 0;
                d++;
            end
        end
    endtask

    initial begin
        //       frame  base n_run tail idx lock uf rs
        set_exp( 0,     0,   0,   0,   0,  1,  0, 0);  // first stream frame discarded
        set_exp( 1,    64,  32,   0,   0,  1,  0, 0);
        set_exp( 2,   128,  32,   0,   0,  1,  0, 0);
        set_exp( 3,   192,  27,   1,  27,  1,  0, 0);  // short frame (7 chunks)
        set_exp( 4,   256,  32,   0,   0,  1,  0, 0);
        set_exp( 5,   320,  32,   0,   0,  0,  0, 1);  // long frame (9 chunks)
        set_exp( 6,     0,   0,   0,   0,  1,  0, 1);
        set_exp( 7,   384,  32,   0,   0,  1,  0, 1);
        set_exp( 8,   448,  24,   0,   0,  0,  8, 2);  // last two chunks withheld
        set_exp( 9,     0,   0,   0,   0,  1,  8, 2);
        set_exp(10,   512,  32,   0,   0,  1,  8, 2);
        set_exp(11,   576,   2,   0,   0,  1,  0, 0);  // reset at idx 2
        set_exp(12,   640,  32,   0,   0,  1,  0, 0);

        for (int f = 0; f < c_NF; f++) begin
            blank_err[f]  = 0;
            locked_end[f] = 1'bx;
            uf_end[f]     = 'x;
            rs_end[f]     = 'x;
            for (int k = 0; k < 32; k++) begin
                obs[f][k] = 'x;
            end
        end

        push_frame(0, 8);
        push_frame(1, 8);
        push_frame(2, 8);
        push_frame(3, 7);
        push_frame(4, 8);
        push_frame(5, 9);
        push_frame(6, 8);
        push_frame(7, 8);
        push_frame(8, 8);
        push_frame(9, 8);
        push_frame(10, 8);

        rst_pixel        = 1'b1;
        h_count          = '0;
        v_count          = '0;
        active_draw      = 1'b0;
        vif.chunk_tvalid = 1'b0;
        vif.chunk_tdata  = '0;
        vif.chunk_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tready", 32'(vif.chunk_tready), 32'd0);
        check("reset_pixel", 32'({pixel_valid, pixel}), 32'({1'b0, c_FILL}));
        check("reset_locked", 32'(frame_locked), 32'd0);
`ifdef VIDEO_ALIGNER_STATS_EN
        check("reset_underflow", 32'(underflow_count), 32'd0);
        check("reset_resync", 32'(resync_count), 32'd0);
`endif

        repeat (c_NF * c_HT * c_VT) cycle();

        for (int f = 0; f < c_NF; f++) begin
            for (int k = 0; k < 32; k++) begin
                logic [16:0] exp_px;
                if (k < tbl[f].n_run) begin
                    exp_px = {1'b1, 16'(tbl[f].base + k)};
                end else if ((k == 31) && tbl[f].tail_valid) begin
                    exp_px = {1'b1, 16'(tbl[f].base + tbl[f].tail_idx)};
                end else begin
                    exp_px = {1'b0, c_FILL};
                end
                check($sformatf("D%0d_k%0d_pixel", f, k), 32'(obs[f][k]), 32'(exp_px));
            end
            check($sformatf("D%0d_blanking_fill", f), 32'(blank_err[f]), 32'd0);
            check($sformatf("D%0d_locked_end", f), 32'(locked_end[f]), 32'(tbl[f].locked));
`ifdef VIDEO_ALIGNER_STATS_EN
            check($sformatf("D%0d_underflow", f), 32'(uf_end[f]), 32'(tbl[f].uf));
            check($sformatf("D%0d_resync", f), 32'(rs_end[f]), 32'(tbl[f].rs));
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
